// File: rtl/fp16_pkg.sv
// Shared fp16 definitions: field widths, canonical quiet NaN, NaN test and the
// state type of the min/max reduction engine.
package fp16_pkg;

  localparam int FP16_W     = 16;
  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;

  localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    CMP_MAX = 2'd1,
    CMP_MIN = 2'd2,
    OUT     = 2'd3
  } fp16_minmax_state_t;

  function automatic logic fp16_is_nan(input logic [FP16_W-1:0] x);
    return (&x[FP16_W-2 -: FP16_EXP_W]) && (|x[FP16_MAN_W-1:0]);
  endfunction

endpackage

// File: rtl/fp16_cmp.sv
// Combinational fp16 magnitude comparator. Zeros of either sign compare equal;
// a NaN on either side makes both gt and lt low.
module fp16_cmp
  import fp16_pkg::*;
(
  input  logic [FP16_W-1:0] a,
  input  logic [FP16_W-1:0] b,
  output logic              gt,
  output logic              lt
);

  logic [FP16_W-2:0] mag_a, mag_b;
  assign mag_a = a[FP16_W-2:0];
  assign mag_b = b[FP16_W-2:0];

  always_comb begin
    gt = 1'b0;
    lt = 1'b0;
    if (fp16_is_nan(a) || fp16_is_nan(b)) begin
      gt = 1'b0;
      lt = 1'b0;
    end else if ((mag_a == '0) && (mag_b == '0)) begin
      gt = 1'b0;
      lt = 1'b0;
    end else if (a[FP16_W-1] != b[FP16_W-1]) begin
      gt = b[FP16_W-1];
      lt = a[FP16_W-1];
    end else if (!a[FP16_W-1]) begin
      gt = mag_a > mag_b;
      lt = mag_a < mag_b;
    end else begin
      // both negative: larger magnitude is the smaller value
      gt = mag_a < mag_b;
      lt = mag_a > mag_b;
    end
  end

endmodule

// File: rtl/fp16_minmax_seq.sv
// Sequential fp16 min/max reduction sharing one comparator across max and min.
// Define FP16_MINMAX_IDX_EN to keep first-occurrence index tracking.
module fp16_minmax_seq
  import fp16_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_max,
  output logic [15:0]       out_min,
  output logic [IDX_W-1:0]  out_max_idx,
  output logic [IDX_W-1:0]  out_min_idx,
  output logic [IDX_W-1:0]  out_count,
  output logic              out_unord,
  output logic              busy
);

  fp16_minmax_state_t state_q, state_d;

  logic [15:0]      sample_q, max_q, min_q;
  logic             last_q, empty_q, unord_q;
  logic [IDX_W-1:0] count_q;
  logic             in_fire, in_nan, cmp_gt, cmp_lt;
  logic [15:0]      cmp_b;

  assign in_fire = in_valid && in_ready;
  assign in_nan  = fp16_is_nan(in_data);
  assign cmp_b   = (state_q == CMP_MIN) ? min_q : max_q;

  fp16_cmp u_cmp (
    .a  (sample_q),
    .b  (cmp_b),
    .gt (cmp_gt),
    .lt (cmp_lt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      FETCH: begin
        in_ready = rst_n;
        if (in_fire) begin
          if (in_nan || empty_q) state_d = in_last ? OUT : FETCH;
          else                   state_d = CMP_MAX;
        end
      end
      CMP_MAX: state_d = CMP_MIN;
      CMP_MIN: state_d = last_q ? OUT : FETCH;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_q <= '0;
      max_q    <= '0;
      min_q    <= '0;
      last_q   <= 1'b0;
      empty_q  <= 1'b1;
      unord_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      case (state_q)
        FETCH: if (in_fire) begin
          sample_q <= in_data;
          last_q   <= in_last;
          if (count_q != {IDX_W{1'b1}}) count_q <= count_q + 1'b1;
          if (in_nan) begin
            unord_q <= 1'b1;
            // an all-NaN vector reports the canonical quiet NaN
            if (empty_q) begin
              max_q <= FP16_QNAN;
              min_q <= FP16_QNAN;
            end
          end else if (empty_q) begin
            max_q   <= in_data;
            min_q   <= in_data;
            empty_q <= 1'b0;
          end
        end
        CMP_MAX: if (cmp_gt) max_q <= sample_q;
        CMP_MIN: if (cmp_lt) min_q <= sample_q;
        OUT: if (out_ready) begin
          count_q <= '0;
          unord_q <= 1'b0;
          empty_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef FP16_MINMAX_IDX_EN
  logic [IDX_W-1:0] sample_idx_q, max_idx_q, min_idx_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_idx_q <= '0;
      max_idx_q    <= '0;
      min_idx_q    <= '0;
    end else begin
      case (state_q)
        FETCH: if (in_fire) begin
          sample_idx_q <= count_q;
          if (in_nan) begin
            if (empty_q) begin
              max_idx_q <= '0;
              min_idx_q <= '0;
            end
          end else if (empty_q) begin
            max_idx_q <= count_q;
            min_idx_q <= count_q;
          end
        end
        CMP_MAX: if (cmp_gt) max_idx_q <= sample_idx_q;
        CMP_MIN: if (cmp_lt) min_idx_q <= sample_idx_q;
        default: ;
      endcase
    end
  end

  assign out_max_idx = max_idx_q;
  assign out_min_idx = min_idx_q;
`else
  assign out_max_idx = '0;
  assign out_min_idx = '0;
`endif

  assign out_max   = max_q;
  assign out_min   = min_q;
  assign out_count = count_q;
  assign out_unord = unord_q;
  assign busy      = !((state_q == FETCH) && empty_q && (count_q == '0));

endmodule

// File: tb/tb_fp16_minmax_seq.sv
// Self-checking bench for fp16_minmax_seq: directed vectors plus random vectors
// checked against a real-valued reference model.
module tb_fp16_minmax_seq;

  localparam int IDX_W = 8;
  localparam int IDX_MAX = (1 << IDX_W) - 1;
`ifdef FP16_MINMAX_IDX_EN
  localparam bit IDX_EN = 1'b1;
`else
  localparam bit IDX_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, in_last;
  logic [15:0]      in_data;
  logic             out_valid, out_ready;
  logic [15:0]      out_max, out_min;
  logic [IDX_W-1:0] out_max_idx, out_min_idx, out_count;
  logic             out_unord, busy;

  int tests = 0;
  int fails = 0;

  logic [15:0] vec[$];
  logic [15:0] e_max, e_min;
  int          e_max_idx, e_min_idx, e_count, e_lat;
  logic        e_unord;

  always #5 clk = ~clk;

  fp16_minmax_seq #(.IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_max(out_max), .out_min(out_min),
    .out_max_idx(out_max_idx), .out_min_idx(out_min_idx),
    .out_count(out_count), .out_unord(out_unord), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_nan(input logic [15:0] h);
    return (h[14:10] == 5'h1f) && (h[9:0] != 0);
  endfunction

  function automatic real to_real(input logic [15:0] h);
    int  e = int'(h[14:10]);
    real v;
    if (e == 0) v = real'(h[9:0]) / 16777216.0;
    else if (e == 31) v = 1.0e9;
    else begin
      v = 1.0 + real'(h[9:0]) / 1024.0;
      for (int k = 0; k < e - 15; k++) v = v * 2.0;
      for (int k = 0; k < 15 - e; k++) v = v / 2.0;
    end
    return h[15] ? -v : v;
  endfunction

  // Reference: first strictly-greater / strictly-smaller non-NaN value wins.
  task automatic model();
    bit  have = 0;
    real mx = 0.0, mn = 0.0, r;
    e_unord = 0; e_max = 16'h7E00; e_min = 16'h7E00; e_max_idx = 0; e_min_idx = 0;
    e_lat = 1;
    for (int i = 0; i < vec.size(); i++) begin
      int idx = (i > IDX_MAX) ? IDX_MAX : i;
      if (i == vec.size() - 1) e_lat = (have && !is_nan(vec[i])) ? 3 : 1;
      if (is_nan(vec[i])) e_unord = 1;
      else begin
        r = to_real(vec[i]);
        if (!have || r > mx) begin mx = r; e_max = vec[i]; e_max_idx = idx; end
        if (!have || r < mn) begin mn = r; e_min = vec[i]; e_min_idx = idx; end
        have = 1;
      end
    end
    e_count = (vec.size() > IDX_MAX) ? IDX_MAX : vec.size();
    if (!IDX_EN) begin e_max_idx = 0; e_min_idx = 0; end
  endtask

  task automatic push(input logic [15:0] d, input logic last);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Streams vec, then checks latency and result while out_valid is high.
  task automatic run_vec(input string tag);
    int lat = 1;
    model();
    for (int i = 0; i < vec.size(); i++) push(vec[i], i == vec.size() - 1);
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(e_lat));
    check({tag, "_max"}, 32'(out_max), 32'(e_max));
    check({tag, "_min"}, 32'(out_min), 32'(e_min));
    check({tag, "_max_idx"}, 32'(out_max_idx), 32'(e_max_idx));
    check({tag, "_min_idx"}, 32'(out_min_idx), 32'(e_min_idx));
    check({tag, "_count"}, 32'(out_count), 32'(e_count));
    check({tag, "_unord"}, 32'(out_unord), 32'(e_unord));
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  function automatic logic [15:0] rnd_sample();
    logic [15:0] h;
    case ($urandom_range(0, 6))
      0: h = {1'($urandom_range(0, 1)), 5'h1f, 10'($urandom_range(1, 1023))};
      1: h = {1'($urandom_range(0, 1)), 15'h0};
      2: h = {1'($urandom_range(0, 1)), 15'h7c00};
      3, 4: case ($urandom_range(0, 3))
        0: h = 16'h3C00; 1: h = 16'hBC00; 2: h = 16'h4000; default: h = 16'h0001;
      endcase
      default: begin
        h = 16'($urandom);
        if (is_nan(h)) h[9:0] = 10'h0;
      end
    endcase
    return h;
  endfunction

  initial begin
    logic [15:0] hold_max, hold_min;
    logic [IDX_W-1:0] hold_cnt;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_max", 32'(out_max), 32'd0);
    check("rst_min", 32'(out_min), 32'd0);
    check("rst_count", 32'(out_count), 32'd0);
    check("rst_unord", 32'(out_unord), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    vec = '{16'h3C00, 16'h4000, 16'hBC00};
    run_vec("basic");
    check("basic_max_const", 32'(out_max), 32'h4000);
    check("basic_min_const", 32'(out_min), 32'hBC00);
    consume("basic");

    vec = '{16'h0000, 16'h8000, 16'h0000};
    run_vec("zeros");
    check("zeros_max_const", 32'(out_max), 32'h0000);
    consume("zeros");

    vec = '{16'h7E00, 16'hC000, 16'h7C00, 16'h7E00};
    run_vec("nanmix");
    check("nanmix_max_const", 32'(out_max), 32'h7C00);
    consume("nanmix");

    vec = '{16'h7E00};
    run_vec("allnan");
    check("allnan_max_const", 32'(out_max), 32'h7E00);
    consume("allnan");

    vec = '{16'h4000, 16'h3C00};
    run_vec("pair");
    consume("pair");

    // hold the result for five cycles with the consumer stalled
    out_ready = 1'b0;
    vec = '{16'hC200, 16'h4500, 16'h4500, 16'hC200};
    run_vec("hold");
    hold_max = out_max; hold_min = out_min; hold_cnt = out_count;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_stable", {out_max, out_min}, {hold_max, hold_min});
      check("hold_count", 32'(out_count), 32'(hold_cnt));
    end
    consume("hold");

    // reset in the middle of a vector discards everything
    push(16'h3C00, 1'b0);
    push(16'h4400, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_max", 32'(out_max), 32'd0);
    check("midrst_min", 32'(out_min), 32'd0);
    check("midrst_idx", {out_max_idx, out_min_idx}, 32'd0);
    check("midrst_count", 32'(out_count), 32'd0);
    check("midrst_unord", 32'(out_unord), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    repeat (4) begin
      @(posedge clk); #1;
      check("midrst_no_result", 32'(out_valid), 32'd0);
    end

    for (int v = 0; v < 25; v++) begin
      int len = $urandom_range(1, 10);
      vec.delete();
      for (int i = 0; i < len; i++) vec.push_back(rnd_sample());
      run_vec("rand");
      consume("rand");
    end

    // long vector crosses the counter saturation point
    vec.delete();
    for (int i = 0; i < 300; i++) vec.push_back(rnd_sample());
    vec[280] = 16'h7BFF;
    vec[290] = 16'hFBFF;
    run_vec("sat");
    consume("sat");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
